// File: rtl/mem_access.sv
// MEM stage access controller: turns EX/MEM load/store requests into a single-outstanding
// request/ack memory transaction, stalls the upstream pipeline and aligns load/store data.
module mem_access (
    input  logic        clk,
    input  logic        rst,
    // EX/MEM inputs
    input  logic [31:0] ALUResIn,
    input  logic [31:0] StoreDataIn,
    input  logic [31:0] PCplus8In,
    input  logic [1:0]  WriteDataSrcIn,
    input  logic [4:0]  WriteRegAddrIn,
    input  logic        RegWE,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemSignExt,
    // MEM/WB outputs
    output logic [31:0] dataMemOut,
    output logic [31:0] ALUResOut,
    output logic [31:0] PCplus8Out,
    output logic [1:0]  WriteDataSrcOut,
    output logic [4:0]  WriteRegAddrOut,
    output logic        RegWE_out,
    // memory port
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    // status
    output logic        stall,
    output logic        misalign
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned BEW  = 4;
    localparam logic [1:0]  SZ_BYTE = 2'b00;
    localparam logic [1:0]  SZ_HALF = 2'b01;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [XLEN-1:0]   mem_addr_q;
    logic [BEW-1:0]    mem_be_q;
    logic [XLEN-1:0]   mem_wdata_q;
    logic [XLEN-1:0]   rdata_q;
    logic              rd_q;
    logic [1:0]        off_q;
    logic [1:0]        size_q;
    logic              sext_q;

    logic              mem_op;
    logic              mis_raw;
    logic              access;
    logic [1:0]        off;
    logic [BEW-1:0]    be_d;
    logic [XLEN-1:0]   wdata_d;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [XLEN-1:0]   load_data;

    assign mem_op = MemRead | MemWrite;
    assign off    = ALUResIn[1:0];

    // Alignment check: halves need addr[0]=0, words (and reserved size) need addr[1:0]=0
    always_comb begin
        mis_raw = 1'b0;
        if (mem_op) begin
            case (MemSize)
                SZ_BYTE: mis_raw = 1'b0;
                SZ_HALF: mis_raw = off[0];
                default: mis_raw = (off != 2'b00);
            endcase
        end
    end

    assign misalign = (state_q == IDLE) & mis_raw;
    assign access   = (state_q == IDLE) & mem_op & ~mis_raw;
    assign stall    = access | (state_q == BUSY);

    // Store lane enables and replicated write data
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = StoreDataIn;
        case (MemSize)
            SZ_BYTE: begin
                be_d    = 4'b0001 << off;
                wdata_d = {4{StoreDataIn[7:0]}};
            end
            SZ_HALF: begin
                be_d    = off[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{StoreDataIn[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = StoreDataIn;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (access)  state_d = BUSY;
            BUSY:    if (mem_ack) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request attributes are captured once on IDLE->BUSY and held until the next access
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            rd_q        <= 1'b0;
            off_q       <= 2'b00;
            size_q      <= 2'b00;
            sext_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_req_q <= (state_d == BUSY);
            if (access) begin
                mem_we_q    <= MemWrite;
                mem_addr_q  <= {ALUResIn[31:2], 2'b00};
                mem_be_q    <= be_d;
                mem_wdata_q <= wdata_d;
                rd_q        <= MemRead & ~MemWrite;
                off_q       <= off;
                size_q      <= MemSize;
                sext_q      <= MemSignExt;
            end
            if ((state_q == BUSY) && mem_ack) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    // Load lane extraction from the captured read word
    always_comb begin
        case (off_q)
            2'd0:    byte_sel = rdata_q[7:0];
            2'd1:    byte_sel = rdata_q[15:8];
            2'd2:    byte_sel = rdata_q[23:16];
            default: byte_sel = rdata_q[31:24];
        endcase
        half_sel = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (size_q)
            SZ_BYTE: load_data = sext_q ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
            SZ_HALF: load_data = sext_q ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
            default: load_data = rdata_q;
        endcase
    end

    assign dataMemOut      = ((state_q == DONE) && rd_q) ? load_data : '0;
    assign ALUResOut       = ALUResIn;
    assign PCplus8Out      = PCplus8In;
    assign WriteDataSrcOut = WriteDataSrcIn;
    assign WriteRegAddrOut = WriteRegAddrIn;
    assign RegWE_out       = RegWE & ~stall & ~misalign;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule
